// File: rtl/fp_pkg.sv
// Shared types for the FP special-case front end: operand classes, output mux
// select codes and the canonical quiet-NaN fraction.
package fp_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_QNAN = 3'd4,
        CLS_SNAN = 3'd5
    } class_e;

    typedef enum logic [1:0] {
        SEL_ADD = 2'b00,
        SEL_BYP = 2'b01,
        SEL_INF = 2'b10,
        SEL_NAN = 2'b11
    } sel_man_e;

    localparam int MAX_FRAC_W = 64;

    // Quiet NaN fraction: MSB set, rest zero; callers slice to their FRAC_W.
    function automatic logic [MAX_FRAC_W-1:0] qnan_frac(input int frac_w);
        return {{(MAX_FRAC_W-1){1'b0}}, 1'b1} << (frac_w - 1);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: maps exponent/fraction to a class_e code.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int DAZ    = 0
) (
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [FRAC_W-1:0] i_frac,
    output class_e            o_class
);

    always_comb begin
        o_class = CLS_NORM;
        if (i_exp == '0) begin
            o_class = (i_frac == '0 || DAZ != 0) ? CLS_ZERO : CLS_SUB;
        end else if (&i_exp) begin
            if (i_frac == '0)            o_class = CLS_INF;
            else if (i_frac[FRAC_W-1])   o_class = CLS_QNAN;
            else                         o_class = CLS_SNAN;
        end
    end

endmodule

// File: rtl/fp_special_case_pipe.sv
// Two-stage special-case resolver in front of the FP adder: S1 classifies,
// S2 resolves the special result and mux selects; sticky flags and a counter.
module fp_special_case_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W       = 8,
    parameter int FRAC_W      = 23,
    parameter int DAZ         = 0,
    parameter int ZERO_BYPASS = 1,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sign_a,
    input  logic [EXP_W-1:0]  i_exp_a,
    input  logic [FRAC_W:0]   i_man_a,
    input  logic              i_sign_b,
    input  logic [EXP_W-1:0]  i_exp_b,
    input  logic [FRAC_W:0]   i_man_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sel_exp,
    output logic [1:0]        o_sel_man,
    output logic              o_spec_sign,
    output logic [EXP_W-1:0]  o_spec_exp,
    output logic [FRAC_W-1:0] o_spec_frac,
    output logic [2:0]        o_class_a,
    output logic [2:0]        o_class_b,
    input  logic              i_flag_clr,
    output logic              o_flag_invalid,
    output logic              o_flag_nan,
    output logic [CNT_W-1:0]  o_special_cnt
);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        class_e            cls;
    } opnd_t;

    typedef struct packed {
        sel_man_e          sel;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        class_e            cls_a;
        class_e            cls_b;
        logic              inv;
    } res_t;

    localparam logic [FRAC_W-1:0] QNAN_FRAC = FRAC_W'(qnan_frac(FRAC_W));

    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    opnd_t            s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    res_t             s2_q, s2_d, res;
    logic             flag_inv_q, flag_inv_d, flag_nan_q, flag_nan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    class_e           cls_a, cls_b;
    logic             s1_load, s2_load, out_hs;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inf_clash;

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .DAZ(DAZ)) u_cls_a (
        .i_exp(i_exp_a), .i_frac(i_man_a[FRAC_W-1:0]), .o_class(cls_a)
    );
    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .DAZ(DAZ)) u_cls_b (
        .i_exp(i_exp_b), .i_frac(i_man_b[FRAC_W-1:0]), .o_class(cls_b)
    );

    assign s2_load = !s2_v_q || i_ready;
    assign s1_load = !s1_v_q || s2_load;
    assign o_ready = s1_load;
    assign out_hs  = s2_v_q && i_ready;

    assign a_nan     = s1_a_q.cls inside {CLS_QNAN, CLS_SNAN};
    assign b_nan     = s1_b_q.cls inside {CLS_QNAN, CLS_SNAN};
    assign a_inf     = s1_a_q.cls == CLS_INF;
    assign b_inf     = s1_b_q.cls == CLS_INF;
    assign a_zero    = s1_a_q.cls == CLS_ZERO;
    assign b_zero    = s1_b_q.cls == CLS_ZERO;
    assign inf_clash = a_inf && b_inf && (s1_a_q.sign != s1_b_q.sign);

    always_comb begin
        res       = '0;
        res.cls_a = s1_a_q.cls;
        res.cls_b = s1_b_q.cls;
        res.inv   = inf_clash || s1_a_q.cls == CLS_SNAN || s1_b_q.cls == CLS_SNAN;
        if (a_nan || b_nan || inf_clash) begin
            res.sel  = SEL_NAN;
            res.exp  = '1;
            res.frac = QNAN_FRAC;
        end else if (a_inf || b_inf) begin
            res.sel  = SEL_INF;
            res.sign = a_inf ? s1_a_q.sign : s1_b_q.sign;
            res.exp  = '1;
        end else if (ZERO_BYPASS != 0 && a_zero && b_zero) begin
            // Exact zero result; DAZ-flushed subnormals must not leak their fraction.
            res.sel  = SEL_BYP;
            res.sign = s1_a_q.sign & s1_b_q.sign;
        end else if (ZERO_BYPASS != 0 && a_zero) begin
            res.sel  = SEL_BYP;
            res.sign = s1_b_q.sign;
            res.exp  = s1_b_q.exp;
            res.frac = s1_b_q.frac;
        end else if (ZERO_BYPASS != 0 && b_zero) begin
            res.sel  = SEL_BYP;
            res.sign = s1_a_q.sign;
            res.exp  = s1_a_q.exp;
            res.frac = s1_a_q.frac;
        end
    end

    always_comb begin
        s1_v_d = s1_load ? i_valid : s1_v_q;
        s1_a_d = s1_a_q;
        s1_b_d = s1_b_q;
        if (s1_load && i_valid) begin
            s1_a_d = '{sign: i_sign_a, exp: i_exp_a, frac: i_man_a[FRAC_W-1:0], cls: cls_a};
            s1_b_d = '{sign: i_sign_b, exp: i_exp_b, frac: i_man_b[FRAC_W-1:0], cls: cls_b};
        end
        s2_v_d = s2_load ? s1_v_q : s2_v_q;
        s2_d   = (s2_load && s1_v_q) ? res : s2_q;

        // A set event on the same cycle as a clear wins.
        flag_inv_d = (flag_inv_q && !i_flag_clr) || (out_hs && s2_q.inv);
        flag_nan_d = (flag_nan_q && !i_flag_clr) || (out_hs && s2_q.sel == SEL_NAN);
        cnt_d      = i_flag_clr ? '0 : cnt_q;
        if (out_hs && s2_q.sel != SEL_ADD) begin
            if (i_flag_clr)   cnt_d = CNT_W'(1);
            else if (~&cnt_q) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_q       <= '0;
            flag_inv_q <= 1'b0;
            flag_nan_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_q       <= s2_d;
            flag_inv_q <= flag_inv_d;
            flag_nan_q <= flag_nan_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid        = s2_v_q;
    assign o_sel_man      = s2_q.sel;
    assign o_sel_exp      = |s2_q.sel;
    assign o_spec_sign    = s2_q.sign;
    assign o_spec_exp     = s2_q.exp;
    assign o_spec_frac    = s2_q.frac;
    assign o_class_a      = s2_q.cls_a;
    assign o_class_b      = s2_q.cls_b;
    assign o_flag_invalid = flag_inv_q;
    assign o_flag_nan     = flag_nan_q;
    assign o_special_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_special_case_pipe.sv
// Randomized + directed bench for fp_special_case_pipe against a rule-level model.
module tb_fp_special_case_pipe;

    localparam int EW = 8;
    localparam int FW = 23;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0, i_ready = 1'b1, i_flag_clr = 1'b0;
    logic          sa = 1'b0, sb = 1'b0;
    logic [EW-1:0] ea = '0, eb = '0;
    logic [FW:0]   ma = '0, mb = '0;
    logic          o_ready, o_valid, o_sel_exp, o_spec_sign, o_flag_invalid, o_flag_nan;
    logic [1:0]    o_sel_man;
    logic [EW-1:0] o_spec_exp;
    logic [FW-1:0] o_spec_frac;
    logic [2:0]    o_class_a, o_class_b;
    logic [CW-1:0] o_special_cnt;

    always #5 clk = ~clk;

    fp_special_case_pipe #(.EXP_W(EW), .FRAC_W(FW), .DAZ(0), .ZERO_BYPASS(1), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign_a(sa), .i_exp_a(ea), .i_man_a(ma),
        .i_sign_b(sb), .i_exp_b(eb), .i_man_b(mb),
        .o_valid(o_valid), .i_ready(i_ready), .o_sel_exp(o_sel_exp), .o_sel_man(o_sel_man),
        .o_spec_sign(o_spec_sign), .o_spec_exp(o_spec_exp), .o_spec_frac(o_spec_frac),
        .o_class_a(o_class_a), .o_class_b(o_class_b), .i_flag_clr(i_flag_clr),
        .o_flag_invalid(o_flag_invalid), .o_flag_nan(o_flag_nan), .o_special_cnt(o_special_cnt)
    );

    typedef struct packed {
        logic [1:0]    sel;
        logic          sg;
        logic [EW-1:0] ex;
        logic [FW-1:0] fr;
        logic [2:0]    ca;
        logic [2:0]    cb;
        logic          inv;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0, n_err = 0;
    logic        m_inv = 1'b0, m_nan = 1'b0;
    int          m_cnt = 0;
    logic        hold_pend = 1'b0, last_acc = 1'b0;
    logic [63:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    // Class codes: 0 zero, 1 sub, 2 norm, 3 inf, 4 qnan, 5 snan.
    function automatic int classify(input logic [EW-1:0] e, input logic [FW:0] m);
        logic [FW-1:0] f;
        f = m[FW-1:0];
        if (e == 0)           return (f == 0) ? 0 : 1;
        if (e == {EW{1'b1}}) begin
            if (f == 0)       return 3;
            return f[FW-1] ? 4 : 5;
        end
        return 2;
    endfunction

    function automatic exp_t model(input logic as, input logic [EW-1:0] ae, input logic [FW:0] am,
                                   input logic bs, input logic [EW-1:0] be, input logic [FW:0] bm);
        exp_t r;
        int   ca, cb;
        bit   clash;
        ca = classify(ae, am);
        cb = classify(be, bm);
        r = '0;
        r.ca = 3'(ca);
        r.cb = 3'(cb);
        clash = (ca == 3 && cb == 3 && as != bs);
        r.inv = clash || ca == 5 || cb == 5;
        if (ca >= 4 || cb >= 4 || clash) begin
            r.sel = 2'b11; r.ex = 8'hFF; r.fr = 23'h400000;
        end else if (ca == 3 || cb == 3) begin
            r.sel = 2'b10; r.ex = 8'hFF; r.sg = (ca == 3) ? as : bs;
        end else if (ca == 0 && cb == 0) begin
            r.sel = 2'b01; r.sg = as & bs;
        end else if (ca == 0) begin
            r.sel = 2'b01; r.sg = bs; r.ex = be; r.fr = bm[FW-1:0];
        end else if (cb == 0) begin
            r.sel = 2'b01; r.sg = as; r.ex = ae; r.fr = am[FW-1:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] out_snap();
        return 64'({o_sel_man, o_sel_exp, o_spec_sign, o_spec_exp, o_spec_frac, o_class_a, o_class_b});
    endfunction

    // One clock: called just after a negedge with inputs already driven.
    task automatic tick();
        exp_t e;
        bit   hs, set_inv, set_nan, inc;
        #1;
        last_acc = 1'b0;
        if (rst) begin
            sbq.delete();
            m_inv = 1'b0; m_nan = 1'b0; m_cnt = 0; hold_pend = 1'b0;
        end else begin
            chk("flag_invalid", 64'(o_flag_invalid), 64'(m_inv));
            chk("flag_nan", 64'(o_flag_nan), 64'(m_nan));
            chk("special_cnt", 64'(o_special_cnt), 64'(m_cnt));
            if (hold_pend) chk("hold_stable", out_snap(), held);
            hold_pend = o_valid && !i_ready;
            held = out_snap();
            hs = 1'b0; set_inv = 1'b0; set_nan = 1'b0; inc = 1'b0;
            if (o_valid) begin
                if (sbq.size() == 0) chk("spurious_valid", 64'(o_valid), 64'(0));
                else if (i_ready) begin
                    e = sbq.pop_front();
                    hs = 1'b1;
                    chk("sel_man", 64'(o_sel_man), 64'(e.sel));
                    chk("sel_exp", 64'(o_sel_exp), 64'(e.sel != 0));
                    chk("spec_val", 64'({o_spec_sign, o_spec_exp, o_spec_frac}), 64'({e.sg, e.ex, e.fr}));
                    chk("class_ab", 64'({o_class_a, o_class_b}), 64'({e.ca, e.cb}));
                    set_inv = e.inv; set_nan = (e.sel == 2'b11); inc = (e.sel != 0);
                end
            end
            m_inv = set_inv || (m_inv && !i_flag_clr);
            m_nan = set_nan || (m_nan && !i_flag_clr);
            if (i_flag_clr) m_cnt = inc ? 1 : 0;
            else if (inc && m_cnt != (1 << CW) - 1) m_cnt++;
            if (i_valid && o_ready) begin
                sbq.push_back(model(sa, ea, ma, sb, eb, mb));
                last_acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ops(input logic as, input logic [EW-1:0] ae, input logic [FW:0] am,
                           input logic bs, input logic [EW-1:0] be, input logic [FW:0] bm);
        sa = as; ea = ae; ma = am; sb = bs; eb = be; mb = bm;
    endtask

    task automatic apply(input logic as, input logic [EW-1:0] ae, input logic [FW:0] am,
                         input logic bs, input logic [EW-1:0] be, input logic [FW:0] bm);
        set_ops(as, ae, am, bs, be, bm);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        i_valid = 1'b0; i_ready = 1'b1; i_flag_clr = 1'b0;
        n = 0;
        while ((sbq.size() != 0 || o_valid) && n < 20) begin tick(); n++; end
        if (n >= 20) chk("drain_timeout", 64'(sbq.size()), 64'(0));
        tick();
    endtask

    task automatic rand_op(output logic s, output logic [EW-1:0] e, output logic [FW:0] m);
        int k;
        k = $urandom_range(0, 9);
        s = 1'($urandom);
        m = (FW+1)'($urandom);
        e = 8'($urandom_range(1, 254));
        case (k)
            0: begin e = 0; m[FW-1:0] = '0; end
            1: begin e = 0; if (m[FW-1:0] == 0) m[0] = 1'b1; end
            2: begin e = 8'hFF; m[FW-1:0] = '0; end
            3: begin e = 8'hFF; m[FW-1] = 1'b1; end
            4: begin e = 8'hFF; m[FW-1] = 1'b0; if (m[FW-1:0] == 0) m[0] = 1'b1; end
            default: ;
        endcase
    endtask

    initial begin
        int acc, cyc;
        @(negedge clk);
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_outs", out_snap(), 64'(0));
        chk("rst_flags", 64'({o_flag_invalid, o_flag_nan, o_special_cnt}), 64'(0));
        chk("rst_ready", 64'(o_ready), 64'(1));

        // 1.0 + 2.0: latency and adder-path selection.
        apply(0, 8'h7F, 24'h800000, 0, 8'h80, 24'h800000);
        chk("lat_early", 64'(o_valid), 64'(0));
        tick();
        chk("lat_2cyc", 64'(o_valid), 64'(1));
        apply(0, 8'h7F, 24'h800000, 0, 8'h80, 24'h800000);
        drain();
        chk("add_cnt0", 64'(o_special_cnt), 64'(0));

        apply(0, 8'hFF, 24'h800000, 1, 8'hFF, 24'h800000);
        drain();
        chk("infinf_flags", 64'({o_flag_invalid, o_flag_nan}), 64'(2'b11));
        chk("infinf_cnt", 64'(o_special_cnt), 64'(1));

        i_flag_clr = 1'b1; tick(); i_flag_clr = 1'b0;
        apply(1, 8'hFF, 24'h800000, 0, 8'h7F, 24'h800000);
        apply(0, 8'hFF, 24'h800001, 0, 8'hFF, 24'h800000);
        apply(0, 8'h00, 24'h000000, 1, 8'h00, 24'h000000);
        apply(1, 8'h00, 24'h000000, 1, 8'h00, 24'h000000);
        apply(0, 8'h00, 24'h000000, 1, 8'h85, 24'h9A0000);
        drain();
        chk("snan_invalid", 64'(o_flag_invalid), 64'(1));

        // Backpressure: four pairs offered while the sink stalls for 3 cycles.
        acc = 0; cyc = 0;
        while ((acc < 4 || sbq.size() != 0) && cyc < 40) begin
            i_ready = (cyc >= 3);
            i_valid = (acc < 4);
            set_ops(0, 8'(8'h70 + acc), 24'h800000, 1, 8'h71, 24'(24'h800000 + acc));
            if (cyc == 2) begin
                #1;
                chk("bp_ready_low", 64'(o_ready), 64'(0));
                chk("bp_valid", 64'(o_valid), 64'(1));
            end
            tick();
            if (last_acc) acc++;
            cyc++;
        end
        if (cyc >= 40) chk("bp_timeout", 64'(acc), 64'(4));
        drain();

        // Reset mid-stream with flags set.
        i_ready = 1'b0;
        apply(0, 8'hFF, 24'hC00000, 0, 8'h01, 24'h800000);
        apply(1, 8'hFF, 24'h800000, 0, 8'hFF, 24'h800000);
        i_ready = 1'b1;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_valid", 64'(o_valid), 64'(0));
        chk("mid_rst_flags", 64'({o_flag_invalid, o_flag_nan, o_special_cnt}), 64'(0));
        chk("mid_rst_ready", 64'(o_ready), 64'(1));

        // Random traffic with random stalls and occasional flag clears.
        for (int i = 0; i < 3000; i++) begin
            logic s1, s2;
            logic [EW-1:0] e1, e2;
            logic [FW:0] m1, m2;
            rand_op(s1, e1, m1);
            rand_op(s2, e2, m2);
            set_ops(s1, e1, m1, s2, e2, m2);
            i_valid    = ($urandom_range(0, 3) != 0);
            i_ready    = ($urandom_range(0, 3) != 0);
            i_flag_clr = ($urandom_range(0, 49) == 0);
            tick();
        end
        drain();
        chk("final_empty", 64'(sbq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
